vx_shift_register_tapped: RTL and testbench



---
 rtl/vx_shift_register_tapped_pkg.sv | 12 +
 rtl/vx_shift_register_tapped_stage.sv | 20 ++
 rtl/vx_shift_register_tapped.sv | 58 +++++
 tb/tb_vx_shift_register_tapped.sv | 115 +++++++++++
 4 files changed

// File: rtl/vx_shift_register_tapped_pkg.sv
// vx_shift_register_tapped_pkg: width helpers and tap-index extraction for the tapped shift register
package vx_shift_register_tapped_pkg;
  function automatic int depthw(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
  function automatic int cntw(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int tap_idx(input logic [255:0] taps, input int k, input int w);
    return int'((taps >> (k * w)) & ((256'd1 << w) - 256'd1));
  endfunction
endpackage

// File: rtl/vx_shift_register_tapped_stage.sv
// vx_shift_register_tapped_stage: one valid+payload stage with partial payload reset
module vx_shift_register_tapped_stage #(
  parameter int DATAW  = 8,
  parameter int RESETW = DATAW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [DATAW-1:0] data_in,
  output logic             valid_out,
  output logic [DATAW-1:0] data_out
);
  localparam logic [DATAW-1:0] RST_MASK = RESETW == 0 ? '0 : {DATAW{1'b1}} >> (DATAW - RESETW);
  always_ff @(posedge clk) begin
    valid_out <= (reset || flush) ? 1'b0 : enable ? valid_in : valid_out;
    data_out  <= reset ? (data_out & ~RST_MASK) : enable ? data_in : data_out;
  end
endmodule

// File: rtl/vx_shift_register_tapped.sv
// vx_shift_register_tapped: stallable tapped delay line with valid tracking, flush and occupancy count
module vx_shift_register_tapped
  import vx_shift_register_tapped_pkg::*;
#(
  parameter int DATAW    = 8,
  parameter int DEPTH    = 4,
  parameter int NUM_TAPS = 1,
  parameter int DEPTHW   = depthw(DEPTH),
  parameter int CNTW     = cntw(DEPTH),
  parameter logic [NUM_TAPS*DEPTHW-1:0] TAPS = '0,
  parameter int RESETW   = DATAW
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      flush,
  input  logic                      valid_in,
  input  logic [DATAW-1:0]          data_in,
  output logic                      valid_out,
  output logic [DATAW-1:0]          data_out,
  output logic [NUM_TAPS-1:0]       tap_valid,
  output logic [NUM_TAPS*DATAW-1:0] tap_data,
  output logic [CNTW-1:0]           count
);
  logic [DEPTH-1:0] v;
  logic [DATAW-1:0] d [DEPTH];
  if (RESETW < 0 || RESETW > DATAW) begin : g_bad_resetw
    $fatal(1, "RESETW must be within 0..DATAW");
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             vi;
    logic [DATAW-1:0] di;
    if (i == 0) begin : g_head
      assign vi = valid_in;
      assign di = data_in;
    end else begin : g_link
      assign vi = v[i-1];
      assign di = d[i-1];
    end
    vx_shift_register_tapped_stage #(.DATAW(DATAW), .RESETW(RESETW)) u_stage (
      .clk(clk), .reset(reset), .enable(enable), .flush(flush),
      .valid_in(vi), .data_in(di), .valid_out(v[i]), .data_out(d[i])
    );
  end
  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    localparam int T = tap_idx(256'(TAPS), k, DEPTHW);
    if (T >= DEPTH) begin : g_bad_tap
      $fatal(1, "tap index out of range");
    end
    assign tap_valid[k] = v[T];
    assign tap_data[k*DATAW +: DATAW] = d[T];
  end
  assign valid_out = v[DEPTH-1];
  assign data_out  = d[DEPTH-1];
  // stage-0 entry minus last-stage exit keeps count equal to the number of valid stages
  always_ff @(posedge clk)
    count <= (reset || flush) ? '0 : enable ? count + CNTW'(valid_in) - CNTW'(v[DEPTH-1]) : count;
endmodule

// File: tb/tb_vx_shift_register_tapped.sv
// tb_vx_shift_register_tapped: directed and random checks against a queue-style reference model
module tb_vx_shift_register_tapped;
  logic clk = 0;
  logic reset, enable, flush, valid_in;
  logic [7:0] data_in;
  logic valid_out;
  logic [7:0] data_out;
  logic [1:0] tap_valid;
  logic [15:0] tap_data;
  logic [2:0] count;
  int n_tests = 0, n_fail = 0;
  logic m_v [4];
  logic [7:0] m_d [4];
  logic [7:0] m_k [4];
  int tidx [2] = '{1, 3};
  always #5 clk = ~clk;
  vx_shift_register_tapped #(
    .DATAW(8), .DEPTH(4), .NUM_TAPS(2), .TAPS(4'b11_01), .RESETW(3)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .valid_in(valid_in), .data_in(data_in), .valid_out(valid_out),
    .data_out(data_out), .tap_valid(tap_valid), .tap_data(tap_data), .count(count)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic f, input logic e, input logic vi, input logic [7:0] di);
    int pc;
    reset = r; flush = f; enable = e; valid_in = vi; data_in = di;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        m_v[i] = 1'b0;
        m_d[i] &= 8'hF8;
        m_k[i] |= 8'h07;
      end
    end else begin
      if (e) begin
        for (int i = 3; i > 0; i--) begin
          m_v[i] = m_v[i-1];
          m_d[i] = m_d[i-1];
          m_k[i] = m_k[i-1];
        end
        m_v[0] = vi;
        m_d[0] = di;
        m_k[0] = 8'hFF;
      end
      if (f) for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
    end
    #1;
    pc = 0;
    for (int i = 0; i < 4; i++) pc += int'(m_v[i]);
    check("valid_out", 32'(valid_out), 32'(m_v[3]));
    check("data_out", 32'(data_out & m_k[3]), 32'(m_d[3] & m_k[3]));
    check("count", 32'(count), 32'(pc));
    for (int k = 0; k < 2; k++) begin
      check($sformatf("tap%0d_valid", k), 32'(tap_valid[k]), 32'(m_v[tidx[k]]));
      check($sformatf("tap%0d_data", k), 32'(tap_data[k*8 +: 8] & m_k[tidx[k]]),
            32'(m_d[tidx[k]] & m_k[tidx[k]]));
    end
  endtask
  initial begin
    for (int i = 0; i < 4; i++) begin
      m_v[i] = 1'b0; m_d[i] = '0; m_k[i] = '0;
    end
    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    check("reset_count", 32'(count), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 1, 8'(8'h11 * (i + 1)));
      check("ramp_count", 32'(count), 32'(i < 3 ? i + 1 : 4));
    end
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, (i % 2) == 0, 1, 8'(8'h11 * (i / 2 + 1)));
    end
    check("stall_first_out", 32'(data_out), 32'h11);
    step(0, 0, 1, 0, 8'h00);
    step(0, 0, 1, 0, 8'h00);
    step(0, 0, 1, 0, 8'h00);
    step(0, 0, 1, 1, 8'hA5);
    step(0, 0, 1, 0, 8'h00);
    check("tap0_pulse", {31'd0, tap_valid[0]}, 32'd1);
    check("tap0_pulse_data", 32'(tap_data[7:0]), 32'hA5);
    step(0, 0, 1, 0, 8'h00);
    step(0, 0, 1, 0, 8'h00);
    check("tap1_pulse", 32'(tap_valid), 32'b10);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 8'(i + 1));
    step(0, 1, 1, 1, 8'h55);
    check("flush_count", 32'(count), 32'd0);
    check("flush_shift", 32'(data_out), 32'h02);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 8'hFF);
    step(1, 0, 0, 0, 8'h00);
    check("partial_rst_out", 32'(data_out), 32'hF8);
    check("partial_rst_taps", 32'(tap_data), 32'hF8F8);
    step(0, 0, 1, 1, 8'h01);
    step(0, 0, 1, 1, 8'h02);
    step(1, 1, 1, 1, 8'h03);
    check("rst_prio_count", 32'(count), 32'd0);
    step(0, 0, 1, 1, 8'h3C);
    check("post_rst_count", 32'(count), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 8'h00);
    check("post_rst_out", {23'd0, valid_out, data_out}, {23'd0, 1'b1, 8'h3C});
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7,
           1'($urandom), 8'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
